// File: rtl/sme_host.sv
// -----------------------------------------------------------------------------
// sme_host
// Front end for the string-matching engine (SME). Buffers one string and one
// pattern loaded over a byte port, serializes them onto the SME character
// interface, waits for the engine result (or a timeout) and returns it as a
// one-cycle result pulse.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   ld_valid/ld_ready       load handshake (accepted only in IDLE)
//   ld_sel, ld_data,ld_last 0=string char, 1=pattern char; ld_last launches a job
//   chardata, isstring,     registered character stream toward the SME
//   ispattern
//   sme_valid/match/index   SME result, sampled only while waiting
//   res_valid/match/index   one-cycle registered result
//   res_timeout, res_error  job ended by timeout / job rejected (no string)
//   str_ovf                 sticky: a character was dropped for capacity
// -----------------------------------------------------------------------------
module sme_host #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ld_valid,
    output logic       ld_ready,
    input  logic       ld_sel,
    input  logic [7:0] ld_data,
    input  logic       ld_last,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_index,
    output logic       res_valid,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       res_timeout,
    output logic       res_error,
    output logic       str_ovf
);
    localparam int SW  = $clog2(STR_MAX + 1);
    localparam int PW  = $clog2(PAT_MAX + 1);
    localparam int SIW = $clog2(STR_MAX);
    localparam int PIW = $clog2(PAT_MAX);
    localparam int IW  = (SW > PW) ? SW : PW;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND_STR = 3'd1,
        S_SEND_PAT = 3'd2,
        S_WAIT     = 3'd3,
        S_REPORT   = 3'd4
    } state_t;

    state_t        r_state, w_state_next;
    logic [IW-1:0] r_idx, w_idx_next;
    logic [SW-1:0] r_str_len;
    logic [PW-1:0] r_pat_len;
    logic          r_str_new, r_str_sent, r_pat_new;
    logic [6:0]    r_tmo;
    logic [7:0]    r_str [STR_MAX];
    logic [7:0]    r_pat [PAT_MAX];

    logic          r_ld_ready, r_isstring, r_ispattern;
    logic [7:0]    r_chardata, w_char_next;
    logic          r_res_valid, r_res_match, r_res_timeout, r_res_error, r_str_ovf;
    logic [4:0]    r_res_index;
    logic          w_err_next, w_tmo_next, w_cap_next;

    // A buffer whose previous contents were consumed (or never loaded) restarts at 0.
    logic          w_ld_acc, w_str_acc, w_pat_acc, w_launch;
    logic [SW-1:0] w_str_base;
    logic [PW-1:0] w_pat_base;
    logic          w_str_wr, w_pat_wr, w_drop, w_tmo_hit;

    assign w_ld_acc   = ld_valid && (r_state == S_IDLE);
    assign w_str_acc  = w_ld_acc && !ld_sel;
    assign w_pat_acc  = w_ld_acc && ld_sel;
    assign w_launch   = w_pat_acc && ld_last;
    assign w_str_base = r_str_new ? r_str_len : '0;
    assign w_pat_base = r_pat_new ? r_pat_len : '0;
    assign w_str_wr   = w_str_acc && (w_str_base < SW'(STR_MAX));
    assign w_pat_wr   = w_pat_acc && (w_pat_base < PW'(PAT_MAX));
    assign w_drop     = (w_str_acc && !w_str_wr) || (w_pat_acc && !w_pat_wr);
    assign w_tmo_hit  = (r_tmo == 7'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Next-state, send index and result-cause decode.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_err_next   = 1'b0;
        w_tmo_next   = 1'b0;
        w_cap_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_idx_next = '0;
                    if (r_str_new) begin
                        w_state_next = S_SEND_STR;
                    end else if (r_str_sent) begin
                        w_state_next = S_SEND_PAT;   // SME still holds the old string
                    end else begin
                        w_state_next = S_REPORT;
                        w_err_next   = 1'b1;
                    end
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_SEND_STR: begin
                if (r_idx == IW'(r_str_len) - IW'(1)) begin
                    w_state_next = S_SEND_PAT;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next   = r_idx + IW'(1);
                end
            end
            S_SEND_PAT: begin
                if (r_idx == IW'(r_pat_len) - IW'(1)) begin
                    w_state_next = S_WAIT;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next   = r_idx + IW'(1);
                end
            end
            S_WAIT: begin
                // A result arriving on the timeout cycle still counts as a result.
                if (sme_valid) begin
                    w_state_next = S_REPORT;
                    w_cap_next   = 1'b1;
                end else if (w_tmo_hit) begin
                    w_state_next = S_REPORT;
                    w_tmo_next   = 1'b1;
                end else begin
                    w_state_next = S_WAIT;
                end
            end
            S_REPORT: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Character for the next cycle; a pattern-only launch may need the byte being written now.
    always_comb begin
        w_char_next = 8'h00;
        case (w_state_next)
            S_SEND_STR: w_char_next = r_str[w_idx_next[SIW-1:0]];
            S_SEND_PAT: begin
                if ((r_state == S_IDLE) && w_pat_wr && (w_pat_base == '0)) begin
                    w_char_next = ld_data;
                end else begin
                    w_char_next = r_pat[w_idx_next[PIW-1:0]];
                end
            end
            default:    w_char_next = 8'h00;
        endcase
    end

    // Registered interface outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ld_ready    <= 1'b1;
            r_isstring    <= 1'b0;
            r_ispattern   <= 1'b0;
            r_chardata    <= 8'h00;
            r_res_valid   <= 1'b0;
            r_res_match   <= 1'b0;
            r_res_index   <= 5'd0;
            r_res_timeout <= 1'b0;
            r_res_error   <= 1'b0;
            r_str_ovf     <= 1'b0;
        end else begin
            r_ld_ready    <= (w_state_next == S_IDLE);
            r_isstring    <= (w_state_next == S_SEND_STR);
            r_ispattern   <= (w_state_next == S_SEND_PAT);
            r_chardata    <= w_char_next;
            r_res_valid   <= (w_state_next == S_REPORT);
            r_res_match   <= w_cap_next && sme_match;
            r_res_index   <= w_cap_next ? sme_index : 5'd0;
            r_res_timeout <= w_tmo_next;
            r_res_error   <= w_err_next;
            r_str_ovf     <= r_str_ovf || w_drop;
        end
    end

    // Buffer lengths and string/pattern bookkeeping flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_str_len  <= '0;
            r_pat_len  <= '0;
            r_str_new  <= 1'b0;
            r_str_sent <= 1'b0;
            r_pat_new  <= 1'b0;
        end else begin
            if (w_str_wr) begin
                r_str_len <= w_str_base + SW'(1);
            end
            if (w_str_acc) begin
                r_str_new <= 1'b1;
            end else if (r_state == S_SEND_STR) begin
                r_str_new  <= 1'b0;
                r_str_sent <= 1'b1;
            end
            if (w_pat_wr) begin
                r_pat_len <= w_pat_base + PW'(1);
            end
            if (w_pat_acc) begin
                r_pat_new <= !ld_last;   // every launch consumes the pattern
            end
        end
    end

    // WAIT-cycle counter: zero outside WAIT, saturating inside.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo <= 7'd0;
        end else if (r_state != S_WAIT) begin
            r_tmo <= 7'd0;
        end else if (r_tmo != 7'h7F) begin
            r_tmo <= r_tmo + 7'd1;
        end
    end

    // Character storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_str_wr) begin
            r_str[w_str_base[SIW-1:0]] <= ld_data;
        end
        if (w_pat_wr) begin
            r_pat[w_pat_base[PIW-1:0]] <= ld_data;
        end
    end

    assign ld_ready    = r_ld_ready;
    assign isstring    = r_isstring;
    assign ispattern   = r_ispattern;
    assign chardata    = r_chardata;
    assign res_valid   = r_res_valid;
    assign res_match   = r_res_match;
    assign res_index   = r_res_index;
    assign res_timeout = r_res_timeout;
    assign res_error   = r_res_error;
    assign str_ovf     = r_str_ovf;

endmodule

// File: doc/sme_host.md
# sme_host

Stimulus and collection front end for the string-matching engine (SME). It buffers one string and one pattern loaded over a simple byte port, then serializes them onto the SME's `chardata`/`isstring`/`ispattern` interface. It waits for the engine's `valid` and returns `match`/`match_index` to the controlling logic as a one-cycle result. It drives the engine's inputs and consumes its outputs.

## Interface
- `STR_MAX`, 32: string buffer depth in characters.
- `PAT_MAX`, 8: pattern buffer depth in characters, including `^`/`$`/`.` metacharacters.
- `TIMEOUT`, 64: maximum WAIT cycles before a job is abandoned.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ld_valid`  in  1  load character present.
- `ld_ready`  out  1  load accepted when `ld_valid & ld_ready`.
- `ld_sel`  in  1  0 = string character, 1 = pattern character.
- `ld_data`  in  8  ASCII character.
- `ld_last`  in  1  with `ld_sel=1`: final pattern character; launches a job.
- `chardata`  out  8  character to SME.
- `isstring`  out  1  SME string strobe.
- `ispattern`  out  1  SME pattern strobe.
- `sme_valid`  in  1  SME result strobe.
- `sme_match`  in  1  SME match flag.
- `sme_index`  in  5  SME match index.
- `res_valid`  out  1  one-cycle result pulse.
- `res_match`  out  1  registered copy of `sme_match`.
- `res_index`  out  5  registered copy of `sme_index`.
- `res_timeout`  out  1  job ended by timeout.
- `res_error`  out  1  job rejected.
- `str_ovf`  out  1  sticky: string or pattern character dropped for capacity.

## Operation
- States:
  - IDLE: `ld_ready=1`.
  - SEND_STR, SEND_PAT, WAIT: `ld_ready=0`.
  - REPORT: one cycle, `res_valid=1`; returns to IDLE.
- Loading, IDLE only:
  - An accepted string character is appended at `str_len` and `str_len` increments.
  - The first string character accepted after a job has consumed the string restarts `str_len` at 0 (new string).
  - Pattern characters behave the same way with `pat_len`; every launched job consumes the pattern.
  - A character arriving while its buffer is full is dropped and sets `str_ovf`. An accepted `ld_last` still launches the job.
- Launch on `ld_last` accepted:
  - If a new string is pending (`str_new`): go to SEND_STR.
  - Else if a string has already been sent since reset (`str_sent`): go to SEND_PAT, reusing the string held in the SME.
  - Else (no string ever loaded): go to REPORT with `res_error=1`, `res_match=0`, `res_index=0`.
- SEND_STR:
  - Drive `isstring=1`, `chardata=str[k]` for k = 0..`str_len`-1 on consecutive cycles.
  - After the last character, go straight to SEND_PAT with no gap.
  - Clear `str_new`; set `str_sent`.
- SEND_PAT: drive `ispattern=1`, `chardata=pat[k]` for k = 0..`pat_len`-1, then go to WAIT.
- `isstring` and `ispattern` are never high together.
- While not sending: `chardata=0`, both strobes 0.
- WAIT:
  - Timeout counter (7-bit, saturating) starts at 0 on the first WAIT cycle.
  - `sme_valid` sampled high: capture `sme_match`/`sme_index` and go to REPORT.
  - Counter reaches `TIMEOUT-1` without `sme_valid`: go to REPORT with `res_timeout=1`, `res_match=0`, `res_index=0`.
  - If `sme_valid` and the timeout occur in the same cycle, `sme_valid` wins.
- `sme_valid` outside WAIT is ignored.
- Reset, including mid-job:
  - Outputs: `chardata=0`, `isstring=0`, `ispattern=0`, `res_*=0`, `str_ovf=0`, `ld_ready=1`.
  - Internal: state = IDLE; `str_len=0`, `pat_len=0`; `str_new=0`, `str_sent=0`.
  - Buffer contents are don't-care.

## Timing
- `ld_last` accepted at edge T: the first `isstring` (or `ispattern`) cycle is T+1.
- Strobes and `chardata` are registered outputs.
- A job with string length L and pattern length P keeps strobes high for exactly L+P consecutive cycles.
- `sme_valid` sampled at edge V: `res_valid` is high in cycle V+1 (REPORT), and IDLE follows at V+2.
- Consequences of that timing:
  - The earliest next load is accepted at edge V+2.
  - The next job's first character therefore never coincides with, or precedes, the cycle after `sme_valid`.
- `res_*` fields are valid only while `res_valid=1`; they return to 0 afterwards.
- `str_ovf` holds until reset.

## Test plan
- Load "abc" plus pattern "b" (`ld_last`). Required drive: `isstring` 3 cycles with 0x61, 0x62, 0x63, then `ispattern` 1 cycle with 0x62. Model replies `sme_valid`, match=1, index=1 → `res_valid` for 1 cycle with `res_match=1`, `res_index=1`.
- Next job loads pattern only "zz" → no `isstring`; `ispattern` 2 cycles of 0x7A. Model match=0 → `res_match=0`.
- Model silent → `res_valid` with `res_timeout=1` exactly 64 WAIT cycles after the last `ispattern` cycle; `ld_ready` high 1 cycle later.
- Load 34 string characters plus pattern "a" → exactly 32 `isstring` cycles; `str_ovf=1`.
- Pattern "a" loaded after reset with no string → no strobes; `res_error=1`.
- Assert `reset` during the 2nd SEND_STR cycle → strobes and `chardata` 0 immediately; `ld_ready=1`; a following pattern-only job reports `res_error=1`.
